// File: rtl/gf180mcu_osu_sc_gp12t3v3__oai31_bist.sv
// gf180mcu_osu_sc_gp12t3v3__oai31_bist: sweeps all 16 OAI31 input vectors, checks Y, and keeps an error count, first failing vector and MISR
module gf180mcu_osu_sc_gp12t3v3__oai31_bist #(
    parameter int SETTLE = 2,
    parameter int LOOPS  = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        Y_DUT,
    output logic        A0,
    output logic        A1,
    output logic        A2,
    output logic        B,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [7:0]  ERR_CNT,
    output logic [3:0]  FAIL_VEC,
    output logic [15:0] SIGNATURE
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t      state;
    logic [3:0]  v;
    logic [3:0]  hold;
    logic [7:0]  loop_cnt;
    logic        mis;
    logic        last_hold;
    logic        last_vec;
    logic [7:0]  err_nxt;
    logic [15:0] sig_nxt;
    always_comb begin
        mis       = Y_DUT != (v <= 4'd8);
        err_nxt   = (mis && ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;
        sig_nxt   = {SIGNATURE[14:0], 1'b0} ^ ({16{SIGNATURE[15] ^ Y_DUT}} & 16'h1021);
        last_hold = hold == 4'(SETTLE);
        last_vec  = v == 4'hF && loop_cnt == 8'(LOOPS - 1);
    end
    // v wraps to 0 on the final sample, so the stimulus is already idle in DONE
    assign {B, A2, A1, A0} = v;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            v         <= 4'd0;
            hold      <= 4'd0;
            loop_cnt  <= 8'd0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= 8'd0;
            FAIL_VEC  <= 4'd0;
            SIGNATURE <= 16'd0;
        end else if (state != S_RUN) begin
            if (START) begin
                state     <= S_RUN;
                v         <= 4'd0;
                hold      <= 4'd0;
                loop_cnt  <= 8'd0;
                BUSY      <= 1'b1;
                DONE      <= 1'b0;
                PASS      <= 1'b0;
                ERR_CNT   <= 8'd0;
                FAIL_VEC  <= 4'd0;
                SIGNATURE <= 16'hFFFF;
            end
        end else if (!last_hold) begin
            hold <= hold + 4'd1;
        end else begin
            hold      <= 4'd0;
            v         <= v + 4'd1;
            ERR_CNT   <= err_nxt;
            SIGNATURE <= sig_nxt;
            if (mis && ERR_CNT == 8'd0)
                FAIL_VEC <= v;
            if (v == 4'hF)
                loop_cnt <= loop_cnt + 8'd1;
            if (last_vec) begin
                state <= S_DONE;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
                PASS  <= err_nxt == 8'd0;
            end
        end
    end
endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__oai31_bist.md
# gf180mcu_osu_sc_gp12t3v3__oai31_bist

Self-checking stimulus and capture stage for silicon and gate-level characterization of the OAI31 cell (Y = ~((A0|A1|A2)&B)). It sits on both sides of one cell instance:
- It drives A0, A1, A2 and B from registers.
- It waits a programmable settle time, then samples the cell's Y.
- It compares the sample against the OAI31 truth table.
- It reports an error count, the first failing vector and a MISR signature.

## Interface
Parameters:
- SETTLE, default 2: extra cycles each vector is held before Y_DUT is sampled. Legal range 0..15.
- LOOPS, default 1: number of full 16-vector sweeps per run. Legal range 1..255.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  single-cycle run request.
- Y_DUT  input  1  output of the cell under test.
- A0, A1, A2, B  output  1 each  registered stimulus to the cell under test.
- BUSY  output  1  run in progress.
- DONE  output  1  run finished. Held high until the next accepted START or RST.
- PASS  output  1  DONE & (ERR_CNT == 0).
- ERR_CNT  output  8  mismatch count, saturating at 255.
- FAIL_VEC  output  4  index {B,A2,A1,A0} of the first mismatch. Meaningful only when ERR_CNT != 0.
- SIGNATURE  output  16  MISR of all sampled Y_DUT bits.

Clock and reset are fixed: one clock, CLK; reset RST is synchronous and active-high.

## Operation
- **Vector index:** v[3:0] = {B,A2,A1,A0}. Sweep order is v = 0,1,…,15, repeated LOOPS times.
- **Expected response:** exp(v) = 0 for v in 9..15, and 1 for v in 0..8.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE / DONE:**
  - A0/A1/A2/B are driven 0.
  - START accepted: ERR_CNT←0, FAIL_VEC←0, SIGNATURE←16'hFFFF, v←0, hold counter←0, loop counter←0, state→RUN.
- **RUN:**
  - Vector v is held for SETTLE+1 cycles.
  - On the last hold cycle, Y_DUT is sampled and compared against exp(v), and the MISR is updated.
  - v then increments, wrapping 15→0 and incrementing the loop counter.
  - After the sample of v=15 in loop LOOPS-1, state→DONE.
- **Mismatch handling:**
  - ERR_CNT increments, saturating at 255.
  - FAIL_VEC is loaded only when ERR_CNT was 0 before this mismatch.
- **MISR update, per sample y:** SIGNATURE ← {SIGNATURE[14:0],1'b0} ^ ({16{SIGNATURE[15]^y}} & 16'h1021).
- **START while BUSY:** ignored.
- **START in DONE:** clears DONE and PASS in the same edge and begins a new run.
- **RST, any state:** all outputs take their reset values at that edge and the FSM returns to IDLE. A run aborted by RST produces no DONE.
- **Reset values:** A0=A1=A2=B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0, SIGNATURE=0.
- **Y_DUT capture:** sampled directly, with no synchronizer. The cell is combinational from registered inputs, and SETTLE covers its propagation.

## Timing
- **Start of run:** START high at edge k → BUSY=1 and vector 0 on outputs from edge k+1.
- **Sample point:** vector n of the run is driven from edge k+1+n·(SETTLE+1). Y_DUT is sampled at edge k+1+n·(SETTLE+1)+SETTLE+1, i.e. the edge that ends its hold window.
- **Run length:** BUSY stays high for exactly 16·LOOPS·(SETTLE+1) cycles.
- **Final result:** DONE=1 and BUSY=0 at the same edge that takes the final sample. ERR_CNT, FAIL_VEC and SIGNATURE are final at that edge.
- **Stimulus in DONE:** stimulus returns to 0 in that same cycle.
- **PASS:** registered together with DONE; never high while BUSY.
- **Vector boundary:** on the edge taking the last sample of one vector, the next vector is driven. Sample and advance happen together.
- **SETTLE=0:** one cycle per vector; Y_DUT is sampled at the edge ending the cycle in which the vector is driven.

## Test plan
- **Golden combinational OAI31 model, SETTLE=2, LOOPS=1:**
  - Required: BUSY high for 48 cycles, then DONE=1, PASS=1, ERR_CNT=0.
  - SIGNATURE equals the bench MISR model over samples 1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0.
- **Y_DUT stuck at 1, LOOPS=1:** ERR_CNT=7, FAIL_VEC=9, PASS=0.
- **Y_DUT stuck at 0, LOOPS=1:** ERR_CNT=9, FAIL_VEC=0, PASS=0.
- **Y_DUT stuck at 1, LOOPS=40:** 280 raw mismatches → ERR_CNT saturates at 255, FAIL_VEC=9, BUSY high for 40·16·3=1920 cycles.
- **Model with one extra register delay on Y, LOOPS=1:**
  - SETTLE=0 → ERR_CNT=1, FAIL_VEC=9.
  - SETTLE=1 → ERR_CNT=0, PASS=1.
- **RST and START interactions:**
  - RST asserted while vector 5 is driven → next edge all outputs at reset values, no DONE.
  - START pulses during a run are ignored; run length unchanged.
  - START in DONE restarts cleanly, with SIGNATURE reseeded to 16'hFFFF.
